// File: rtl/wb_dma_mem_arbiter.sv
// Arbitrates the CPU Wishbone slave port and the DMA master port onto one single-port BRAM.
// Define ARB_RR_EN for round-robin tie-breaking; default is fixed DMA-over-CPU priority.
module wb_dma_mem_arbiter #(
  parameter logic [31:0] BASE_ADDR    = 32'h3800_0000,
  parameter int          MEM_WORDS    = 1024,
  parameter int          READ_LATENCY = 1,
  localparam int         ADDR_W       = $clog2(MEM_WORDS)
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cpu_stb_i,
  input  logic              cpu_cyc_i,
  input  logic              cpu_we_i,
  input  logic [3:0]        cpu_sel_i,
  input  logic [31:0]       cpu_adr_i,
  input  logic [31:0]       cpu_dat_i,
  output logic              cpu_ack_o,
  output logic [31:0]       cpu_dat_o,
  input  logic              dma_stb_i,
  input  logic              dma_cyc_i,
  input  logic              dma_we_i,
  input  logic [3:0]        dma_sel_i,
  input  logic [31:0]       dma_adr_i,
  input  logic [31:0]       dma_dat_i,
  output logic              dma_ack_o,
  output logic [31:0]       dma_dat_o,
  output logic              dma_err_o,
  output logic              mem_en_o,
  output logic [3:0]        mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  output logic [1:0]        grant_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  localparam logic [32:0] WIN_END = {1'b0, BASE_ADDR} + 33'(4 * MEM_WORDS);

  function automatic logic in_win(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < WIN_END);
  endfunction

  state_t            state, nxt;
  logic              owner_dma, r_we, aborted, capture, pick_dma, own_cyc;
  logic [3:0]        r_sel;
  logic [2:0]        cnt;
  logic              cpu_in, dma_in, cpu_req, dma_req;
  logic [ADDR_W-1:0] cpu_word, dma_word;

  assign cpu_in   = in_win(cpu_adr_i);
  assign dma_in   = in_win(dma_adr_i);
  // Out-of-window CPU accesses belong to another slave, so they never request here.
  assign cpu_req  = cpu_stb_i & cpu_cyc_i & cpu_in;
  assign dma_req  = dma_stb_i & dma_cyc_i;
  assign cpu_word = ADDR_W'((cpu_adr_i - BASE_ADDR) >> 2);
  assign dma_word = ADDR_W'((dma_adr_i - BASE_ADDR) >> 2);
  assign own_cyc  = owner_dma ? dma_cyc_i : cpu_cyc_i;

`ifdef ARB_RR_EN
  logic last_owner;
  assign pick_dma = dma_req & (~cpu_req | ~last_owner);
`else
  assign pick_dma = dma_req;
`endif

  always_comb begin
    nxt       = state;
    mem_en_o  = 1'b0;
    mem_we_o  = 4'h0;
    cpu_ack_o = 1'b0;
    dma_ack_o = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE:  if (cpu_req || dma_req) nxt = (pick_dma && !dma_in) ? ACK : ISSUE;
      ISSUE: begin
        mem_en_o = 1'b1;
        mem_we_o = r_we ? r_sel : 4'h0;
        nxt      = r_we ? ACK : WAIT;
      end
      WAIT:  if (cnt == 3'd1) begin
        nxt     = ACK;
        capture = ~aborted & own_cyc;
      end
      ACK: begin
        cpu_ack_o = ~owner_dma & ~aborted;
        dma_ack_o = owner_dma & ~aborted;
        nxt       = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      owner_dma   <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= 4'h0;
      aborted     <= 1'b0;
      cnt         <= 3'd0;
      grant_o     <= 2'b00;
      mem_addr_o  <= '0;
      mem_wdata_o <= 32'h0;
      cpu_dat_o   <= 32'h0;
      dma_dat_o   <= 32'h0;
      dma_err_o   <= 1'b0;
`ifdef ARB_RR_EN
      last_owner  <= 1'b0;
`endif
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (cpu_req || dma_req) begin
          owner_dma <= pick_dma;
          grant_o   <= pick_dma ? 2'b10 : 2'b01;
          aborted   <= 1'b0;
          if (pick_dma && !dma_in) begin
            // Error path never reaches the BRAM: read data forced to 0, write dropped.
            dma_err_o <= 1'b1;
            dma_dat_o <= 32'h0;
          end else if (pick_dma) begin
            r_we        <= dma_we_i;
            r_sel       <= dma_sel_i;
            mem_addr_o  <= dma_word;
            mem_wdata_o <= dma_dat_i;
          end else begin
            r_we        <= cpu_we_i;
            r_sel       <= cpu_sel_i;
            mem_addr_o  <= cpu_word;
            mem_wdata_o <= cpu_dat_i;
          end
        end
        ISSUE: begin
          cnt <= 3'(READ_LATENCY);
          if (!own_cyc) aborted <= 1'b1;
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (!own_cyc) aborted <= 1'b1;
          if (capture) begin
            if (owner_dma) dma_dat_o <= mem_rdata_i;
            else           cpu_dat_o <= mem_rdata_i;
          end
        end
        ACK: begin
          grant_o <= 2'b00;
`ifdef ARB_RR_EN
          last_owner <= owner_dma;
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_dma_mem_arbiter.sv
// Directed bench: READ_LATENCY=1 instance (suffix 1) and READ_LATENCY=3 instance (suffix 3)
// share all Wishbone inputs; each has its own BRAM model preloaded with 0xD000_0000 | word.
module tb_wb_dma_mem_arbiter;
  logic        clk = 1'b0, rst = 1'b0, preload = 1'b1;
  logic        cpu_stb, cpu_cyc, cpu_we, dma_stb, dma_cyc, dma_we;
  logic [3:0]  cpu_sel, dma_sel;
  logic [31:0] cpu_adr, cpu_dat, dma_adr, dma_dat;

  logic        c_ack1, d_ack1, err1, en1, c_ack3, d_ack3, err3, en3;
  logic [31:0] c_dat1, d_dat1, wd1, rd1, c_dat3, d_dat3, wd3, rd3;
  logic [3:0]  we1, we3;
  logic [9:0]  addr1, addr3;
  logic [1:0]  gr1, gr3;

  logic [31:0] mem1 [1024];
  logic [31:0] mem3 [1024];
  logic [31:0] p1, q0, q1, q2;

  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  wb_dma_mem_arbiter #(.READ_LATENCY(1)) u1 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cpu_stb_i(cpu_stb), .cpu_cyc_i(cpu_cyc), .cpu_we_i(cpu_we), .cpu_sel_i(cpu_sel),
    .cpu_adr_i(cpu_adr), .cpu_dat_i(cpu_dat), .cpu_ack_o(c_ack1), .cpu_dat_o(c_dat1),
    .dma_stb_i(dma_stb), .dma_cyc_i(dma_cyc), .dma_we_i(dma_we), .dma_sel_i(dma_sel),
    .dma_adr_i(dma_adr), .dma_dat_i(dma_dat), .dma_ack_o(d_ack1), .dma_dat_o(d_dat1),
    .dma_err_o(err1), .mem_en_o(en1), .mem_we_o(we1), .mem_addr_o(addr1),
    .mem_wdata_o(wd1), .mem_rdata_i(rd1), .grant_o(gr1));

  wb_dma_mem_arbiter #(.READ_LATENCY(3)) u3 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cpu_stb_i(cpu_stb), .cpu_cyc_i(cpu_cyc), .cpu_we_i(cpu_we), .cpu_sel_i(cpu_sel),
    .cpu_adr_i(cpu_adr), .cpu_dat_i(cpu_dat), .cpu_ack_o(c_ack3), .cpu_dat_o(c_dat3),
    .dma_stb_i(dma_stb), .dma_cyc_i(dma_cyc), .dma_we_i(dma_we), .dma_sel_i(dma_sel),
    .dma_adr_i(dma_adr), .dma_dat_i(dma_dat), .dma_ack_o(d_ack3), .dma_dat_o(d_dat3),
    .dma_err_o(err3), .mem_en_o(en3), .mem_we_o(we3), .mem_addr_o(addr3),
    .mem_wdata_o(wd3), .mem_rdata_i(rd3), .grant_o(gr3));

  assign rd1 = p1;
  assign rd3 = q2;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) begin
        mem1[i] <= 32'hD000_0000 | 32'(i);
        mem3[i] <= 32'hD000_0000 | 32'(i);
      end
    end else begin
      if (en1) begin
        for (int b = 0; b < 4; b++) if (we1[b]) mem1[addr1][8*b +: 8] <= wd1[8*b +: 8];
        p1 <= mem1[addr1];
      end
      if (en3) begin
        for (int b = 0; b < 4; b++) if (we3[b]) mem3[addr3][8*b +: 8] <= wd3[8*b +: 8];
        q0 <= mem3[addr3];
      end
      q1 <= q0;
      q2 <= q1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_drive(input logic req, input logic we, input logic [31:0] adr,
                           input logic [31:0] dat);
    cpu_stb = req; cpu_cyc = req; cpu_we = we; cpu_adr = adr; cpu_dat = dat; cpu_sel = 4'hF;
  endtask

  task automatic dma_drive(input logic req, input logic we, input logic [31:0] adr,
                           input logic [31:0] dat);
    dma_stb = req; dma_cyc = req; dma_we = we; dma_adr = adr; dma_dat = dat; dma_sel = 4'hF;
  endtask

  task automatic do_reset;
    cpu_drive(0, 0, 32'h0, 32'h0);
    dma_drive(0, 0, 32'h0, 32'h0);
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    cpu_drive(0, 0, 32'h0, 32'h0);
    dma_drive(0, 0, 32'h0, 32'h0);
    rst = 1'b1;
    #2;
    n_cmp++;
    if ({c_ack1, c_dat1, d_ack1, d_dat1, err1, en1, we1, addr1, wd1, gr1} !== '0) begin
      n_bad++; $display("FAIL reset_rl1 got %h want 0", {c_dat1, d_dat1, wd1, addr1, gr1});
    end
    n_cmp++;
    if ({c_ack3, c_dat3, d_ack3, d_dat3, err3, en3, we3, addr3, wd3, gr3} !== '0) begin
      n_bad++; $display("FAIL reset_rl3 got %h want 0", {c_dat3, d_dat3, wd3, addr3, gr3});
    end
    tick; tick;
    preload = 1'b0;
    rst = 1'b0;
    tick;
    n_cmp++;
    if ({gr1, en1, c_ack1, d_ack1} !== 5'b0) begin
      n_bad++; $display("FAIL idle_after_reset got %b want 0", {gr1, en1, c_ack1, d_ack1});
    end
  endtask

  task automatic test_cpu_wr_rd;
    do_reset;
    cpu_drive(1, 1, 32'h3800_0010, 32'hA5A5_1234);
    tick;
    n_cmp++;
    if ({en1, addr1, we1, wd1} !== {1'b1, 10'd4, 4'hF, 32'hA5A5_1234}) begin
      n_bad++; $display("FAIL wr_issue got en=%b addr=%0d we=%h wd=%h want 1 4 f a5a51234",
                        en1, addr1, we1, wd1);
    end
    tick;
    n_cmp++;
    if (c_ack1 !== 1'b1) begin n_bad++; $display("FAIL wr_ack_t2 got %b want 1", c_ack1); end
    cpu_drive(1, 0, 32'h3800_0010, 32'h0);
    tick;
    n_cmp++;
    if (c_ack1 !== 1'b0) begin n_bad++; $display("FAIL wr_ack_pulse got %b want 0", c_ack1); end
    tick;
    n_cmp++;
    if ({en1, we1} !== {1'b1, 4'h0}) begin
      n_bad++; $display("FAIL rd_issue got en=%b we=%h want 1 0", en1, we1);
    end
    tick;
    n_cmp++;
    if (c_ack1 !== 1'b0) begin n_bad++; $display("FAIL rd_ack_early got %b want 0", c_ack1); end
    tick;
    n_cmp++;
    if ({c_ack1, c_dat1} !== {1'b1, 32'hA5A5_1234}) begin
      n_bad++; $display("FAIL rd_ack_t3 got ack=%b dat=%h want 1 a5a51234", c_ack1, c_dat1);
    end
    cpu_drive(0, 0, 32'h0, 32'h0);
  endtask

  task automatic test_dma_burst;
    logic gap_bad = 1'b0, cpu_seen = 1'b0;
    logic [31:0] adr = 32'h3800_0100;
    do_reset;
    dma_drive(1, 0, adr, 32'h0);
    for (int i = 0; i < 11; i++) begin
      for (int k = 1; k <= ((i == 0) ? 3 : 4); k++) begin
        tick;
        if (c_ack1) cpu_seen = 1'b1;
        if (k < ((i == 0) ? 3 : 4) && d_ack1) gap_bad = 1'b1;
      end
      n_cmp++;
      if ({d_ack1, d_dat1} !== {1'b1, 32'hD000_0040 + 32'(i)}) begin
        n_bad++; $display("FAIL burst_beat%0d got ack=%b dat=%h want 1 %h", i, d_ack1, d_dat1,
                          32'hD000_0040 + 32'(i));
      end
      adr = adr + 32'd4;
      if (i == 10) dma_drive(0, 0, 32'h0, 32'h0);
      else         dma_drive(1, 0, adr, 32'h0);
    end
    n_cmp++;
    if (gap_bad !== 1'b0) begin n_bad++; $display("FAIL burst_spacing got %b want 0", gap_bad); end
    n_cmp++;
    if (cpu_seen !== 1'b0) begin n_bad++; $display("FAIL burst_cpu_ack got %b want 0", cpu_seen); end
  endtask

  task automatic test_dma_err;
    logic seen = 1'b0;
    do_reset;
    dma_drive(1, 0, 32'h3800_0100, 32'h0);
    tick; tick; tick;
    dma_drive(1, 0, 32'h3000_0000, 32'h0);
    tick; tick;
    n_cmp++;
    if ({d_ack1, d_dat1, err1, en1} !== {1'b1, 32'h0, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL err_ack got ack=%b dat=%h err=%b en=%b want 1 0 1 0",
                        d_ack1, d_dat1, err1, en1);
    end
    dma_drive(0, 0, 32'h0, 32'h0);
    cpu_drive(1, 0, 32'h3000_0000, 32'h0);
    for (int k = 0; k < 6; k++) begin
      tick;
      if (c_ack1 || c_ack3 || en1 || gr1 != 2'b00) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL cpu_oow_ignored got %b want 0", seen); end
    n_cmp++;
    if (err1 !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %b want 1", err1); end
    cpu_drive(0, 0, 32'h0, 32'h0);
  endtask

  task automatic test_abort;
    do_reset;
    dma_drive(1, 0, 32'h3800_0100, 32'h0);
    tick; tick;
    dma_drive(0, 0, 32'h3800_0100, 32'h0);
    tick;
    n_cmp++;
    if (d_ack1 !== 1'b0) begin n_bad++; $display("FAIL abort_ack got %b want 0", d_ack1); end
    tick;
    n_cmp++;
    if ({gr1, d_ack1, d_dat1} !== '0) begin
      n_bad++; $display("FAIL abort_idle got gr=%b ack=%b dat=%h want 0 0 0", gr1, d_ack1, d_dat1);
    end
  endtask

  task automatic test_arb_tie;
    logic [1:0] exp2;
    do_reset;
    cpu_drive(1, 0, 32'h3800_0010, 32'h0);
    dma_drive(1, 0, 32'h3800_0100, 32'h0);
    tick;
    n_cmp++;
    if (gr1 !== 2'b10) begin n_bad++; $display("FAIL tie_grant got %b want 10", gr1); end
    tick; tick;
    n_cmp++;
    if ({d_ack1, c_ack1} !== 2'b10) begin
      n_bad++; $display("FAIL tie_dma_first got d=%b c=%b want 1 0", d_ack1, c_ack1);
    end
    dma_drive(0, 0, 32'h0, 32'h0);
    tick; tick; tick; tick;
    n_cmp++;
    if ({c_ack1, c_dat1, d_ack1} !== {1'b1, 32'hA5A5_1234, 1'b0}) begin
      n_bad++; $display("FAIL tie_cpu_second got c=%b dat=%h d=%b want 1 a5a51234 0",
                        c_ack1, c_dat1, d_ack1);
    end
    cpu_drive(0, 0, 32'h0, 32'h0);
    do_reset;
    cpu_drive(1, 0, 32'h3800_0010, 32'h0);
    dma_drive(1, 0, 32'h3800_0100, 32'h0);
    tick; tick; tick; tick; tick;
`ifdef ARB_RR_EN
    exp2 = 2'b01;
`else
    exp2 = 2'b10;
`endif
    n_cmp++;
    if (gr1 !== exp2) begin n_bad++; $display("FAIL tie_second_grant got %b want %b", gr1, exp2); end
    cpu_drive(0, 0, 32'h0, 32'h0);
    dma_drive(0, 0, 32'h0, 32'h0);
  endtask

  task automatic test_rl3;
    logic seen = 1'b0;
    do_reset;
    cpu_drive(1, 0, 32'h3800_0FFC, 32'h0);
    tick;
    n_cmp++;
    if ({en3, addr3, we3} !== {1'b1, 10'd1023, 4'h0}) begin
      n_bad++; $display("FAIL rl3_issue got en=%b addr=%0d we=%h want 1 1023 0", en3, addr3, we3);
    end
    for (int k = 2; k <= 4; k++) begin
      tick;
      if (c_ack3) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL rl3_ack_early got %b want 0", seen); end
    tick;
    n_cmp++;
    if ({c_ack3, c_dat3} !== {1'b1, 32'hD000_03FF}) begin
      n_bad++; $display("FAIL rl3_ack_t5 got ack=%b dat=%h want 1 d00003ff", c_ack3, c_dat3);
    end
    cpu_drive(0, 0, 32'h0, 32'h0);
    tick; tick;
    seen = 1'b0;
    cpu_drive(1, 0, 32'h3800_1000, 32'h0);
    for (int k = 0; k < 8; k++) begin
      tick;
      if (c_ack1 || c_ack3 || en3 || gr3 != 2'b00) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL rl3_past_end got %b want 0", seen); end
    cpu_drive(0, 0, 32'h0, 32'h0);
  endtask

  task automatic test_reset_mid_wait;
    do_reset;
    cpu_drive(1, 0, 32'h3800_0FFC, 32'h0);
    tick;
    n_cmp++;
    if (gr3 !== 2'b01) begin n_bad++; $display("FAIL mid_wait_grant got %b want 01", gr3); end
    tick;
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({c_ack3, c_dat3, d_ack3, d_dat3, err3, en3, we3, addr3, wd3, gr3} !== '0) begin
      n_bad++; $display("FAIL mid_wait_reset got gr=%b en=%b addr=%0d dat=%h want 0",
                        gr3, en3, addr3, c_dat3);
    end
    cpu_drive(0, 0, 32'h0, 32'h0);
    tick;
    rst = 1'b0;
    tick;
  endtask

  initial begin
    cpu_drive(0, 0, 32'h0, 32'h0);
    dma_drive(0, 0, 32'h0, 32'h0);
    test_reset;
    test_cpu_wr_rd;
    test_dma_burst;
    test_dma_err;
    test_abort;
    test_arb_tie;
    test_rl3;
    test_reset_mid_wait;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/wb_dma_mem_arbiter.md
Name: wb_dma_mem_arbiter

Overview:
Shared-memory front end that arbitrates the CPU Wishbone slave port and the DMA engine's Wishbone master port onto one single-port, word-addressed user BRAM. The DMA engine streams FIR taps, input data and matrix operands from this BRAM and writes results back into it. This block generates the DMA-side ack and read data that pace that engine, and the CPU-side ack and read data.

Parameters:
BASE_ADDR, 32'h3800_0000, byte base address of the memory window.
MEM_WORDS, 1024, window size in 32-bit words; ADDR_W = clog2(MEM_WORDS).
READ_LATENCY, 1, BRAM read latency in cycles (legal 1..7).

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset
cpu_stb_i / cpu_cyc_i / cpu_we_i  in  1 each  CPU Wishbone strobe, cycle, write enable
cpu_sel_i  in  4  CPU byte selects
cpu_adr_i  in  32  CPU byte address
cpu_dat_i  in  32  CPU write data
cpu_ack_o  out  1  CPU ack, one-cycle pulse
cpu_dat_o  out  32  CPU read data, valid with cpu_ack_o
dma_stb_i / dma_cyc_i / dma_we_i  in  1 each  DMA strobe, cycle, write enable
dma_sel_i  in  4  DMA byte selects
dma_adr_i  in  32  DMA byte address
dma_dat_i  in  32  DMA write data
dma_ack_o  out  1  DMA ack, one-cycle pulse
dma_dat_o  out  32  DMA read data, valid with dma_ack_o
dma_err_o  out  1  sticky: DMA issued an out-of-window access
mem_en_o  out  1  BRAM enable
mem_we_o  out  4  BRAM byte write enables
mem_addr_o  out  ADDR_W  BRAM word address
mem_wdata_o  out  32  BRAM write data
mem_rdata_i  in  32  BRAM read data, READ_LATENCY cycles after mem_en_o
grant_o  out  2  current owner: 00 none, 01 CPU, 10 DMA

Behaviour:
- Reset: wb_rst_i is asynchronous and active-high; clock is wb_clk_i. On reset all outputs are 0, the FSM returns to IDLE, any in-flight access is abandoned without ack, and dma_err_o is cleared.
- Request definition: a port requests when stb & cyc. It is in-window when BASE_ADDR <= adr < BASE_ADDR + 4*MEM_WORDS. mem_addr_o = (adr - BASE_ADDR) >> 2.
- CPU requests that are out of window are ignored: no ack; another slave decodes them.
- DMA requests that are out of window go IDLE -> ACK directly. They set dma_err_o, reads return 0, writes are dropped, and the BRAM is not touched.
- FSM: IDLE -> ISSUE -> WAIT -> ACK -> IDLE.
  - IDLE: evaluate requests and register the winner, its address, we, sel and data. Go to ISSUE. With no request, stay in IDLE and hold grant_o at 00.
  - ISSUE (1 cycle): mem_en_o = 1; mem_we_o = sel if we, else 0. Writes go to ACK. Reads load the latency counter with READ_LATENCY and go to WAIT.
  - WAIT: decrement the counter. When it reaches 0, capture mem_rdata_i into the winner's dat_o register and go to ACK.
  - ACK (1 cycle): pulse the winner's ack_o, then go to IDLE. The non-winner's ack_o stays 0.
- Latency, with a request first sampled in IDLE at cycle T:
  - Write ack in cycle T+2.
  - Read ack in cycle T+2+READ_LATENCY.
  - DMA error ack in cycle T+1.
- Back-to-back accesses: a request still asserted in the IDLE cycle after ACK is treated as a new access. A master that keeps stb high after its ack therefore issues a repeat access. Throughput is one access per 3+READ_LATENCY cycles for reads.
- Default arbitration is fixed priority, DMA over CPU, applied on simultaneous requests in IDLE. Once granted, an access is never pre-empted.
- Abort: if the owner drops cyc during ISSUE or WAIT, the BRAM cycle still completes but ack_o is suppressed. A write already issued stays written.
- cpu_dat_o and dma_dat_o hold their last captured value between acks.
- mem_wdata_o and mem_addr_o hold their last value outside ISSUE; only mem_en_o qualifies them.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: round-robin arbitration. A one-bit last_owner register is updated in ACK. On simultaneous requests, the port that did not own the previous access wins; last_owner resets to CPU, so the first tie goes to DMA.
- Undefined: fixed DMA-over-CPU priority as above, with no last_owner register.

Test Plan:
- CPU write then read, READ_LATENCY=1: write 32'hA5A5_1234 to 32'h3800_0010 -> mem_en_o with mem_addr_o=4 and mem_we_o=4'hF at T+1, cpu_ack_o at T+2. Read back -> cpu_ack_o at T+3 with cpu_dat_o=32'hA5A5_1234.
- DMA burst read of 11 words from 32'h3800_0100, stb held high -> 11 dma_ack_o pulses spaced 4 cycles apart, dma_dat_o equal to memory words 64..74, cpu_ack_o never high.
- CPU and DMA request in the same cycle, both reads:
  - Default: DMA is acked first, CPU 4 cycles later.
  - ARB_RR_EN, two consecutive ties: first grant DMA, second grant CPU.
- DMA read of 32'h3000_0000 -> dma_ack_o at T+1, dma_dat_o=0, dma_err_o=1 and sticky, mem_en_o stays 0. CPU read of the same address -> no ack.
- Abort and reset:
  - DMA read started, dma_cyc_i dropped in WAIT -> no dma_ack_o, FSM back in IDLE.
  - wb_rst_i asserted mid-WAIT -> all outputs 0 immediately, grant_o=00.
- READ_LATENCY=3, CPU read of 32'h3800_0FFC (last word) -> mem_addr_o=1023, cpu_ack_o at T+5. Read of 32'h3800_1000 -> no ack.
